// File: rtl/cape_gpio_ctrl.sv
// cape_gpio_ctrl: APB-controlled GPIO block with per-pin ownership mux,
// a shared blink prescaler, a 3-flop input synchroniser and edge interrupts.
//
// APB handshake: pready is tied high, so every transfer has zero wait states.
// A write commits at the edge where psel & penable & pwrite are all 1.
// Read data is captured at the setup-phase edge (psel & !penable & !pwrite)
// and holds through the access phase and beyond, until the next setup phase.
module cape_gpio_ctrl #(
  parameter int NPINS = 28,
  parameter int DIV_W = 24
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [7:0]        paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  input  logic [NPINS-1:0]  core_oe,
  input  logic [NPINS-1:0]  core_out,
  input  logic [NPINS-1:0]  pad_in,
  output logic [NPINS-1:0]  pad_oe,
  output logic [NPINS-1:0]  pad_out,
  output logic [NPINS-1:0]  gpio_in,
  output logic              irq
);

  localparam logic [5:0] A_OWN   = 6'd0;
  localparam logic [5:0] A_OUT   = 6'd1;
  localparam logic [5:0] A_OE    = 6'd2;
  localparam logic [5:0] A_BLINK = 6'd3;
  localparam logic [5:0] A_DIV   = 6'd4;
  localparam logic [5:0] A_IN    = 6'd5;
  localparam logic [5:0] A_IEN   = 6'd6;
  localparam logic [5:0] A_IEDGE = 6'd7;
  localparam logic [5:0] A_ISTAT = 6'd8;

  logic [NPINS-1:0] r_own, r_out, r_oe, r_blink_en;
  logic [DIV_W-1:0] r_div, r_cnt;
  logic             r_blink;
  logic [NPINS-1:0] r_irq_en, r_irq_edge, r_irq_stat;
  logic [NPINS-1:0] r_s1, r_s2, r_s3;
  logic [31:0]      r_prdata;

  logic [5:0]       w_idx;
  logic             w_wr;
  logic             w_rd_setup;
  logic [31:0]      w_rdata;
  logic [NPINS-1:0] w_rise, w_fall, w_evt, w_clr;
  logic [NPINS-1:0] w_reg_out;
  logic             w_unused;

  assign w_idx      = paddr[7:2];
  assign w_wr       = psel & penable & pwrite;
  assign w_rd_setup = psel & ~penable & ~pwrite;
  assign w_unused   = ^{paddr[1:0], pwdata};

  // Control register writes; IN and unmapped addresses fall through untouched.
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_own      <= '0;
      r_out      <= '0;
      r_oe       <= '0;
      r_blink_en <= '0;
      r_div      <= '0;
      r_irq_en   <= '0;
      r_irq_edge <= '0;
    end else if (w_wr) begin
      case (w_idx)
        A_OWN:   r_own      <= pwdata[NPINS-1:0];
        A_OUT:   r_out      <= pwdata[NPINS-1:0];
        A_OE:    r_oe       <= pwdata[NPINS-1:0];
        A_BLINK: r_blink_en <= pwdata[NPINS-1:0];
        A_DIV:   r_div      <= pwdata[DIV_W-1:0];
        A_IEN:   r_irq_en   <= pwdata[NPINS-1:0];
        A_IEDGE: r_irq_edge <= pwdata[NPINS-1:0];
        default: ;
      endcase
    end
  end

  // Blink prescaler: reload and toggle at zero; a DIV write restarts it at zero
  // so the new divisor takes effect on the very next edge.
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_blink <= 1'b0;
    end else if (w_wr && (w_idx == A_DIV)) begin
      r_cnt   <= '0;
    end else if (r_cnt == '0) begin
      r_cnt   <= r_div;
      r_blink <= ~r_blink;
    end else begin
      r_cnt   <= r_cnt - 1'b1;
    end
  end

  // Pad input synchroniser; s3 is kept only for edge detection.
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
    end else begin
      r_s1 <= pad_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_rise = r_s2 & ~r_s3;
  assign w_fall = ~r_s2 & r_s3;
  assign w_evt  = (r_irq_edge & w_rise) | (~r_irq_edge & w_fall);
  assign w_clr  = (w_wr && (w_idx == A_ISTAT)) ? pwdata[NPINS-1:0] : '0;

  // Interrupt status: W1C, with a same-cycle new event taking priority.
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_irq_stat <= '0;
    end else begin
      r_irq_stat <= (r_irq_stat & ~w_clr) | w_evt;
    end
  end

  // Read data mux, zero-extended to the bus width.
  always_comb begin
    w_rdata = '0;
    case (w_idx)
      A_OWN:   w_rdata = 32'(r_own);
      A_OUT:   w_rdata = 32'(r_out);
      A_OE:    w_rdata = 32'(r_oe);
      A_BLINK: w_rdata = 32'(r_blink_en);
      A_DIV:   w_rdata = 32'(r_div);
      A_IN:    w_rdata = 32'(r_s2);
      A_IEN:   w_rdata = 32'(r_irq_en);
      A_IEDGE: w_rdata = 32'(r_irq_edge);
      A_ISTAT: w_rdata = 32'(r_irq_stat);
      default: w_rdata = '0;
    endcase
  end

  // Read data capture at the setup phase; holds otherwise.
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_prdata <= '0;
    end else if (w_rd_setup) begin
      r_prdata <= w_rdata;
    end
  end

  assign w_reg_out = (r_blink_en & {NPINS{r_blink}}) | (~r_blink_en & r_out);

  assign pad_oe  = (r_own & r_oe) | (~r_own & core_oe);
  assign pad_out = (r_own & w_reg_out) | (~r_own & core_out);
  assign gpio_in = r_s2;
  assign irq     = |(r_irq_stat & r_irq_en);
  assign prdata  = r_prdata;
  assign pready  = 1'b1;

endmodule

// File: tb/tb_cape_gpio_ctrl.sv
// Testbench for cape_gpio_ctrl: register table, blink/IRQ corner sequences,
// randomized traffic against a bus-monitor reference model, reset abort.
module tb_cape_gpio_ctrl;

  localparam int NPINS = 28;
  localparam int DIV_W = 24;
  localparam logic [31:0] PMASK = (NPINS == 32) ? 32'hFFFF_FFFF : ((32'h1 << NPINS) - 1);
  localparam logic [31:0] DMASK = (DIV_W == 32) ? 32'hFFFF_FFFF : ((32'h1 << DIV_W) - 1);

  logic              pclk;
  logic              rst;
  logic              psel, penable, pwrite;
  logic [7:0]        paddr;
  logic [31:0]       pwdata;
  logic [31:0]       prdata;
  logic              pready;
  logic [NPINS-1:0]  core_oe, core_out, pad_in;
  logic [NPINS-1:0]  pad_oe, pad_out, gpio_in;
  logic              irq;

  cape_gpio_ctrl #(.NPINS(NPINS), .DIV_W(DIV_W)) dut (
    .pclk(pclk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .core_oe(core_oe), .core_out(core_out), .pad_in(pad_in),
    .pad_oe(pad_oe), .pad_out(pad_out), .gpio_in(gpio_in), .irq(irq)
  );

  // ---------------- clock ----------------
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // ---------------- scoreboard counters ----------------
  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (bus monitor) ----------------
  // Register file indexed by word address; pad history holds the pad value
  // sampled at the most recent edges (index 0 newest).
  logic [31:0]      m_reg [0:8];
  logic [NPINS-1:0] m_hist [$];
  logic             m_blink;
  longint           m_since;
  logic [31:0]      m_prdata;

  function automatic logic [31:0] m_read(input logic [7:0] a);
    int idx;
    idx = int'(a[7:2]);
    if (idx == 5) return 32'(m_hist[1]);
    if (idx <= 8) return m_reg[idx];
    return 32'h0;
  endfunction

  always @(posedge pclk) begin
    logic [NPINS-1:0] s2, s3, rise, fall, evt, edg;
    int idx;
    bit wr;
    if (rst) begin
      for (int i = 0; i <= 8; i++) m_reg[i] = 32'h0;
      m_hist = '{'0, '0, '0};
      m_blink = 1'b0;
      m_since = 0;
      m_prdata = 32'h0;
    end else begin
      idx = int'(paddr[7:2]);
      wr = psel && penable && pwrite;
      if (psel && !penable && !pwrite) m_prdata = m_read(paddr);
      s2 = m_hist[1];
      s3 = m_hist[2];
      edg = m_reg[7][NPINS-1:0];
      rise = s2 & ~s3;
      fall = ~s2 & s3;
      evt = (edg & rise) | (~edg & fall);
      // Blink: toggles on edges 1, 1+(D+1), 1+2(D+1)... after the last restart.
      if (wr && idx == 4) begin
        m_since = 0;
      end else begin
        m_since++;
        if (((m_since - 1) % (longint'(m_reg[4]) + 1)) == 0) m_blink = ~m_blink;
      end
      if (wr && idx == 8) m_reg[8] = m_reg[8] & ~pwdata;
      m_reg[8] = m_reg[8] | 32'(evt);
      if (wr && (idx <= 3 || idx == 6 || idx == 7)) m_reg[idx] = pwdata & PMASK;
      if (wr && idx == 4) m_reg[4] = pwdata & DMASK;
      m_hist.push_front(pad_in);
      void'(m_hist.pop_back());
    end
  end

  function automatic logic [31:0] exp_oe();
    logic [NPINS-1:0] own, oe;
    own = m_reg[0][NPINS-1:0];
    oe  = m_reg[2][NPINS-1:0];
    return 32'((own & oe) | (~own & core_oe));
  endfunction

  function automatic logic [31:0] exp_out();
    logic [NPINS-1:0] own, ben, out, sel;
    own = m_reg[0][NPINS-1:0];
    out = m_reg[1][NPINS-1:0];
    ben = m_reg[3][NPINS-1:0];
    sel = (ben & {NPINS{m_blink}}) | (~ben & out);
    return 32'((own & sel) | (~own & core_out));
  endfunction

  function automatic logic [31:0] exp_irq();
    return 32'(|(m_reg[8] & m_reg[6]));
  endfunction

  // Continuous output check, away from the active edge.
  always @(negedge pclk) begin
    if (chk_en && !rst) begin
      chk("mon_pad_oe", 32'(pad_oe), exp_oe());
      chk("mon_pad_out", 32'(pad_out), exp_out());
      chk("mon_gpio_in", 32'(gpio_in), 32'(m_hist[1]));
      chk("mon_irq", 32'(irq), exp_irq());
    end
  end

  // ---------------- driver tasks (called #1 after a rising edge) ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge pclk);
      #1;
    end
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
    paddr = a; pwdata = d; psel = 1'b1; pwrite = 1'b1; penable = 1'b0;
    tick(1);
    penable = 1'b1;
    tick(1);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
    paddr = a; psel = 1'b1; pwrite = 1'b0; penable = 1'b0;
    tick(1);
    penable = 1'b1;
    d = prdata;
    chk("rd_model", d, m_prdata);
    tick(1);
    psel = 1'b0; penable = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vtab [14];

  initial begin
    logic [31:0] rd;
    logic [15:0] tog;
    logic        prev;

    vtab[0]  = '{"own_mask",   8'h00, 32'hFFFF_FFFF, PMASK};
    vtab[1]  = '{"out_mask",   8'h04, 32'hA5A5_A5A5, 32'hA5A5_A5A5 & PMASK};
    vtab[2]  = '{"oe_mask",    8'h08, 32'h1234_5678, 32'h1234_5678 & PMASK};
    vtab[3]  = '{"blink_zero", 8'h0C, 32'h0000_0000, 32'h0};
    vtab[4]  = '{"div_mask",   8'h10, 32'hFFFF_FFFF, DMASK};
    vtab[5]  = '{"div_small",  8'h13, 32'h0000_0003, 32'h3};
    vtab[6]  = '{"in_ro",      8'h14, 32'hFFFF_FFFF, 32'h0};
    vtab[7]  = '{"ien_zero",   8'h18, 32'h0000_0000, 32'h0};
    vtab[8]  = '{"iedge_mask", 8'h1C, 32'hFFFF_FFFF, PMASK};
    vtab[9]  = '{"iedge_zero", 8'h1C, 32'h0000_0000, 32'h0};
    vtab[10] = '{"istat_w1c",  8'h20, 32'hFFFF_FFFF, 32'h0};
    vtab[11] = '{"unmap_24",   8'h24, 32'hFFFF_FFFF, 32'h0};
    vtab[12] = '{"unmap_3c",   8'h3C, 32'hFFFF_FFFF, 32'h0};
    vtab[13] = '{"own_clear",  8'h01, 32'h0000_0000, 32'h0};

    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 8'h0; pwdata = 32'h0;
    core_oe = '1; core_out = '1; pad_in = '0;
    tick(3);
    rst = 1'b0;
    chk_en = 1'b1;

    // Reset state: everything pass-through, no interrupt.
    chk("rst_pad_oe", 32'(pad_oe), PMASK);
    chk("rst_pad_out", 32'(pad_out), PMASK);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_pready", 32'(pready), 32'h1);
    apb_read(8'h00, rd);
    chk("rst_own_rd", rd, 32'h0);

    // Register table: write, read back, compare against the table.
    for (int i = 0; i < 14; i++) begin
      apb_write(vtab[i].addr, vtab[i].wdata);
      apb_read(vtab[i].addr, rd);
      chk(vtab[i].name, rd, vtab[i].exp);
    end

    // Blink on pins 6:5 with D=3: toggle every 4 cycles.
    core_out = 28'h5A5_A5A5 & PMASK[NPINS-1:0];
    apb_write(8'h00, 32'h60);
    apb_write(8'h08, 32'h60);
    apb_write(8'h0C, 32'h60);
    apb_write(8'h10, 32'h3);
    prev = pad_out[5];
    tog = '0;
    for (int i = 0; i < 16; i++) begin
      tick(1);
      tog[i] = (pad_out[5] !== prev);
      prev = pad_out[5];
      chk("blink_pair", 32'(pad_out[6]), 32'(pad_out[5]));
    end
    chk("blink_pattern", 32'(tog), 32'h1111);

    // Rising-edge interrupt on pin 0 with exact latency.
    apb_write(8'h18, 32'h1);
    apb_write(8'h1C, 32'h1);
    apb_write(8'h20, 32'hFFFF_FFFF);
    pad_in[0] = 1'b1;
    tick(1);
    chk("sync_k", 32'(gpio_in[0]), 32'h0);
    tick(1);
    chk("sync_k1", 32'(gpio_in[0]), 32'h1);
    chk("irq_k1", 32'(irq), 32'h0);
    tick(1);
    chk("irq_k2", 32'(irq), 32'h1);
    apb_read(8'h20, rd);
    chk("stat_k2", rd, 32'h1);
    apb_write(8'h20, 32'h1);
    chk("irq_cleared", 32'(irq), 32'h0);

    // Falling edge is ignored in rising mode; then re-arm status to 1.
    pad_in[0] = 1'b0;
    tick(4);
    chk("fall_ignored", 32'(irq), 32'h0);
    pad_in[0] = 1'b1;
    tick(4);
    chk("stat_rearm", 32'(irq), 32'h1);
    pad_in[0] = 1'b0;
    tick(4);
    // New rising edge lands on the same edge as the W1C commit.
    pad_in[0] = 1'b1;
    tick(1);
    apb_write(8'h20, 32'h1);
    chk("set_wins_irq", 32'(irq), 32'h1);
    apb_read(8'h20, rd);
    chk("set_wins_stat", rd, 32'h1);
    apb_write(8'h20, 32'h1);

    // Changing edge polarity and ownership with a steady pad sets nothing.
    apb_write(8'h1C, 32'h0);
    apb_write(8'h00, 32'h0);
    tick(4);
    apb_read(8'h20, rd);
    chk("no_spurious", rd, 32'h0);

    // Randomized traffic checked by the monitor and the read model.
    for (int it = 0; it < 400; it++) begin
      int op;
      op = $urandom_range(0, 3);
      if (op <= 1) begin
        pad_in   = NPINS'($urandom);
        core_oe  = NPINS'($urandom);
        core_out = NPINS'($urandom);
        tick($urandom_range(1, 3));
      end else if (op == 2) begin
        int r;
        logic [31:0] d;
        r = $urandom_range(0, 7);
        d = $urandom;
        case (r)
          0: apb_write(8'h00, d);
          1: apb_write(8'h04, d);
          2: apb_write(8'h08, d);
          3: apb_write(8'h0C, d);
          4: apb_write(8'h10, 32'($urandom_range(0, 4)));
          5: apb_write(8'h18, d);
          6: apb_write(8'h1C, d);
          default: apb_write(8'h20, d);
        endcase
      end else begin
        apb_read(8'($urandom_range(0, 63)), rd);
      end
    end

    // prdata holds its value outside of read setup phases.
    apb_read(8'h08, rd);
    tick(3);
    chk("prdata_hold", prdata, rd);

    // Reset asserted during the access phase aborts the write.
    paddr = 8'h04; pwdata = 32'hFF; psel = 1'b1; pwrite = 1'b1; penable = 1'b0;
    tick(1);
    penable = 1'b1;
    rst = 1'b1;
    tick(1);
    rst = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    chk("abort_irq", 32'(irq), 32'h0);
    chk("abort_prdata", prdata, 32'h0);
    apb_read(8'h04, rd);
    chk("abort_out", rd, 32'h0);
    apb_read(8'h00, rd);
    chk("abort_own", rd, 32'h0);

    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
